ttt_turn_ctrl: RTL and testbench
================================

Name: ttt_turn_ctrl

Overview:
- Turn sequencer and arbiter for the 3x3 game board that drives the nine 2-bit cell states consumed by the board-to-LED-matrix renderer.
- Accepts move requests from two player input sources and grants only the player whose turn it is.
- Writes each accepted move into a board register, then checks all eight lines for a win, and a full board for a draw.
- Output cell ports connect one-to-one to the renderer's cell inputs.

Parameters:
- FIRST_PLAYER, 1, player granted the first turn after reset or new_game (1 or 2).
- TIMEOUT_CYCLES, 50_000_000, turn-timeout length in clk cycles; used only with MOVE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- new_game  in  1  synchronous restart; clears the board and returns to the first turn.
- p1_req  in  1  player 1 move request; held until acked or nacked.
- p1_cell  in  4  player 1 target cell, 0..8.
- p2_req  in  1  player 2 move request.
- p2_cell  in  4  player 2 target cell, 0..8.
- p1_ack, p2_ack  out  1  one-cycle pulse: move accepted.
- p1_nack, p2_nack  out  1  one-cycle pulse: move rejected.
- cell0..cell8  out  2 each  cell state: 00 empty, 01 player 1, 10 player 2; 11 is never driven.
- turn  out  2  player to move: 01 or 10; 00 when the game is over.
- game_over  out  1  high in WIN and DRAW.
- winner  out  2  01 or 10 on a win; 00 on a draw or while in play.

Behaviour:
- Reset, while reset==0:
  - all cells 00.
  - state=WAIT_P(FIRST_PLAYER); turn reflects FIRST_PLAYER.
  - ack, nack, game_over and winner all 0; move counter 0.
  - Reset mid-game or mid-CHECK discards everything.
- States: WAIT_P1, WAIT_P2, CHECK, WIN, DRAW.
- WAIT_Px:
  - Only px_req is evaluated; the other player's req is ignored and gets no ack or nack, so it stays pending.
  - Accept when px_req=1, px_cell<=8, and that cell is 00:
    - cell written with the player code at that edge.
    - px_ack pulses the following cycle.
    - move counter +1; go to CHECK, with last mover recorded.
  - Reject when px_cell>=9 or the cell is non-zero:
    - px_nack pulses the following cycle; board and state unchanged.
  - A requester must drop req after its ack or nack. A req still high in the cycle its ack or nack is visible is not re-evaluated. A re-evaluation requires req to go low for at least one cycle (rising-edge qualified).
- CHECK (1 cycle):
  - Evaluate rows 012/345/678, columns 036/147/258, diagonals 048/246 for the last mover's code.
  - Any line complete -> WIN, winner = mover code.
  - Else counter==9 -> DRAW.
  - Else -> WAIT of the other player.
  - turn=00 during CHECK; all reqs ignored.
- WIN/DRAW: game_over=1, turn=00, board frozen, all reqs ignored. Leave only via new_game or reset.
- new_game=1 in any state:
  - next edge clears the board, counter, winner and game_over; enters WAIT_P(FIRST_PLAYER).
  - new_game wins over a simultaneous accept: no write, no ack.
- Latency: req sampled at edge N -> cell visible after N; ack/nack high cycle N+1; turn switches at N+2.
- All outputs registered.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- Defined:
  - A per-turn counter resets on every entry to WAIT_Px and counts cycles in WAIT_Px.
  - At TIMEOUT_CYCLES-1 with no accept, the turn passes to the other player: no board change, counter unchanged.
  - A nack does not restart the timer.
  - Adds output timeout_pulse (1 bit), high for one cycle on forfeit.
- Undefined: no timer logic and no timeout_pulse port; a turn waits indefinitely.

Test Plan:
- Reset (reset=0, 3 cycles, then 1), FIRST_PLAYER=1 -> all cells 00, turn=01, game_over=0, winner=00.
- P1 cell 0, P2 cell 4, P1 cell 2, P2 cell 8, P1 cell 1:
  - each produces exactly one ack.
  - after the last move: cell0=cell1=cell2=01, cell4=cell8=10, game_over=1, winner=01, turn=00.
- P1 cell 4 accepted, then P2 cell 4, then P2 cell 11:
  - each P2 request gets p2_nack with no board change; turn stays 10.
  - p1_req held high during WAIT_P2 gets no ack/nack.
- Nine-move draw (P1: 0,2,3,7,5; P2: 1,4,6,8) -> DRAW after the ninth ack: game_over=1, winner=00.
- reset=0 asserted asynchronously between two edges during CHECK -> outputs clear immediately with no clock edge needed. new_game asserted in WIN -> next cycle board all 00, turn=01.
- With MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=8, P1 idle -> timeout_pulse after 8 cycles in WAIT_P1, turn=10, board unchanged.

Source files
------------

// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl: 3x3 game turn arbiter, board register and win/draw detector.
// Optional MOVE_TIMEOUT_EN adds a per-turn forfeit timer and timeout_pulse output.
module ttt_turn_ctrl #(
  parameter int FIRST_PLAYER   = 1,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       p1_req,
  input  logic [3:0] p1_cell,
  input  logic       p2_req,
  input  logic [3:0] p2_cell,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic       p1_nack,
  output logic       p2_nack,
  output logic [1:0] cell0,
  output logic [1:0] cell1,
  output logic [1:0] cell2,
  output logic [1:0] cell3,
  output logic [1:0] cell4,
  output logic [1:0] cell5,
  output logic [1:0] cell6,
  output logic [1:0] cell7,
  output logic [1:0] cell8,
  output logic [1:0] turn,
  output logic       game_over,
  output logic [1:0] winner
`ifdef MOVE_TIMEOUT_EN
  ,
  output logic       timeout_pulse
`endif
);
  typedef enum logic [2:0] {WAIT_P1, WAIT_P2, CHECK, WIN, DRAW} state_t;
  localparam state_t     FIRST_WAIT = (FIRST_PLAYER == 2) ? WAIT_P2 : WAIT_P1;
  localparam logic [1:0] FIRST_CODE = (FIRST_PLAYER == 2) ? 2'b10 : 2'b01;
  state_t state, next_state;
  logic [1:0] board [9];
  logic [3:0] moves;
  logic [1:0] mover, cur_code, turn_d, winner_d;
  logic [3:0] cur_cell;
  logic [15:0] occ;
  logic [8:0] own;
  logic p1_armed, p2_armed, in_wait, cur_req, accept, reject, win, timeout;
  logic game_over_d, p1_ack_d, p2_ack_d, p1_nack_d, p2_nack_d;
  genvar i;
  // cells 9..15 read as occupied so out-of-range targets reject naturally
  for (i = 0; i < 9; i++) begin : g_cell
    assign occ[i] = |board[i];
    assign own[i] = board[i] == mover;
  end
  assign occ[15:9] = '1;
  assign {cell8, cell7, cell6, cell5, cell4, cell3, cell2, cell1, cell0} =
    {board[8], board[7], board[6], board[5], board[4], board[3], board[2], board[1], board[0]};
  assign win = (&own[2:0]) | (&own[5:3]) | (&own[8:6]) |
               (own[0] & own[3] & own[6]) | (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
               (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  assign in_wait  = state == WAIT_P1 || state == WAIT_P2;
  assign cur_req  = state == WAIT_P1 ? p1_req & p1_armed : p2_req & p2_armed;
  assign cur_cell = state == WAIT_P1 ? p1_cell : p2_cell;
  assign cur_code = state == WAIT_P1 ? 2'b01 : 2'b10;
  assign accept   = in_wait & cur_req & ~occ[cur_cell] & ~new_game;
  assign reject   = in_wait & cur_req & occ[cur_cell] & ~new_game;
`ifdef MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign timeout = in_wait & ~accept & ~new_game & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) tcnt <= '0;
    else tcnt <= (new_game || next_state != state) ? '0 : in_wait ? tcnt + 1'b1 : tcnt;
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= FIRST_WAIT;
      turn      <= FIRST_CODE;
      game_over <= 1'b0;
      winner    <= 2'b00;
      p1_ack    <= 1'b0;
      p2_ack    <= 1'b0;
      p1_nack   <= 1'b0;
      p2_nack   <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      turn      <= turn_d;
      game_over <= game_over_d;
      winner    <= winner_d;
      p1_ack    <= p1_ack_d;
      p2_ack    <= p2_ack_d;
      p1_nack   <= p1_nack_d;
      p2_nack   <= p2_nack_d;
`ifdef MOVE_TIMEOUT_EN
      timeout_pulse <= timeout;
`endif
    end
  always_comb begin
    next_state = state;
    if (new_game) next_state = FIRST_WAIT;
    else if (in_wait) next_state = accept ? CHECK : timeout ? (state == WAIT_P1 ? WAIT_P2 : WAIT_P1) : state;
    else if (state == CHECK) next_state = win ? WIN : moves == 4'd9 ? DRAW : mover == 2'b01 ? WAIT_P2 : WAIT_P1;
  end
  always_comb begin
    turn_d      = next_state == WAIT_P1 ? 2'b01 : next_state == WAIT_P2 ? 2'b10 : 2'b00;
    game_over_d = next_state == WIN || next_state == DRAW;
    winner_d    = new_game ? 2'b00 : (state == CHECK && win) ? mover : winner;
    p1_ack_d    = accept && state == WAIT_P1;
    p2_ack_d    = accept && state == WAIT_P2;
    p1_nack_d   = reject && state == WAIT_P1;
    p2_nack_d   = reject && state == WAIT_P2;
  end
  // a response disarms the requester until it drops req for a cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      board    <= '{default: 2'b00};
      moves    <= 4'd0;
      mover    <= 2'b00;
      p1_armed <= 1'b1;
      p2_armed <= 1'b1;
    end else begin
      if (new_game) begin
        board <= '{default: 2'b00};
        moves <= 4'd0;
        mover <= 2'b00;
      end else if (accept) begin
        board[cur_cell] <= cur_code;
        moves           <= moves + 4'd1;
        mover           <= cur_code;
      end
      p1_armed <= (p1_ack_d || p1_nack_d) ? 1'b0 : (~p1_req | p1_armed);
      p2_armed <= (p2_ack_d || p2_nack_d) ? 1'b0 : (~p2_req | p2_armed);
    end
endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// tb_ttt_turn_ctrl: directed self-checking bench for ttt_turn_ctrl.
module tb_ttt_turn_ctrl;
  logic clk = 0, reset = 0, new_game = 0, p1_req = 0, p2_req = 0;
  logic [3:0] p1_cell = 0, p2_cell = 0;
  logic p1_ack, p2_ack, p1_nack, p2_nack, game_over;
  logic [1:0] cell0, cell1, cell2, cell3, cell4, cell5, cell6, cell7, cell8, turn, winner;
`ifdef MOVE_TIMEOUT_EN
  logic timeout_pulse;
`endif
  int n_chk = 0, n_pass = 0;
  int a1 = 0, a2 = 0, k1 = 0, k2 = 0;
  logic ga, gn;

  ttt_turn_ctrl #(.FIRST_PLAYER(1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .p1_req(p1_req), .p1_cell(p1_cell), .p2_req(p2_req), .p2_cell(p2_cell),
    .p1_ack(p1_ack), .p2_ack(p2_ack), .p1_nack(p1_nack), .p2_nack(p2_nack),
    .cell0(cell0), .cell1(cell1), .cell2(cell2), .cell3(cell3), .cell4(cell4),
    .cell5(cell5), .cell6(cell6), .cell7(cell7), .cell8(cell8),
    .turn(turn), .game_over(game_over), .winner(winner)
`ifdef MOVE_TIMEOUT_EN
    , .timeout_pulse(timeout_pulse)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (p1_ack) a1 <= a1 + 1;
    if (p2_ack) a2 <= a2 + 1;
    if (p1_nack) k1 <= k1 + 1;
    if (p2_nack) k2 <= k2 + 1;
  end

  function automatic logic [17:0] brd();
    return {cell8, cell7, cell6, cell5, cell4, cell3, cell2, cell1, cell0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic move(input int p, input logic [3:0] c, output logic got_ack, output logic got_nack);
    got_ack = 0;
    got_nack = 0;
    if (p == 1) begin p1_cell = c; p1_req = 1; end
    else begin p2_cell = c; p2_req = 1; end
    for (int i = 0; i < 20 && !(got_ack || got_nack); i++) begin
      @(posedge clk); #1;
      got_ack  = (p == 1) ? p1_ack : p2_ack;
      got_nack = (p == 1) ? p1_nack : p2_nack;
    end
    check("response", {31'd0, got_ack | got_nack}, 1);
    if (p == 1) p1_req = 0; else p2_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic restart();
    new_game = 1;
    @(posedge clk); #1;
    new_game = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pl_w[5] = '{1, 2, 1, 2, 1};
    logic [3:0] cl_w[5] = '{0, 4, 2, 8, 1};
    int pl_d[9] = '{1, 2, 1, 2, 1, 2, 1, 2, 1};
    logic [3:0] cl_d[9] = '{0, 1, 2, 4, 3, 6, 7, 8, 5};
    int b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_board", brd(), 0);
    check("rst_turn", turn, 2'b01);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    check("init_board", brd(), 0);
    check("init_turn", turn, 2'b01);
    check("init_over", game_over, 0);
    check("init_winner", winner, 0);
    // row 0-1-2 win for player 1
    for (int i = 0; i < 5; i++) begin
      b = a1 + a2;
      move(pl_w[i], cl_w[i], ga, gn);
      check("win_ack", a1 + a2 - b, 1);
      check("win_nack", gn, 0);
    end
    check("win_board", brd(), 18'b10_00_00_00_10_00_01_01_01);
    check("win_over", game_over, 1);
    check("win_winner", winner, 2'b01);
    check("win_turn", turn, 2'b00);
    restart();
    check("ng_board", brd(), 0);
    check("ng_turn", turn, 2'b01);
    check("ng_over", game_over, 0);
    check("ng_winner", winner, 0);
    // rejections while player 1 holds a stale request
    move(1, 4, ga, gn);
    check("rej_first_ack", ga, 1);
    check("rej_board0", brd(), 18'b00_00_00_00_01_00_00_00_00);
    p1_cell = 5;
    p1_req = 1;
    b = a1 + k1;
    move(2, 4, ga, gn);
    check("rej_occ_nack", gn, 1);
    check("rej_occ_ack", ga, 0);
    check("rej_occ_board", brd(), 18'b00_00_00_00_01_00_00_00_00);
    check("rej_occ_turn", turn, 2'b10);
    move(2, 11, ga, gn);
    check("rej_range_nack", gn, 1);
    check("rej_range_board", brd(), 18'b00_00_00_00_01_00_00_00_00);
    check("rej_range_turn", turn, 2'b10);
    check("rej_p1_ignored", a1 + k1 - b, 0);
    p1_req = 0;
    restart();
    for (int i = 0; i < 9; i++) begin
      b = a1 + a2;
      move(pl_d[i], cl_d[i], ga, gn);
      check("draw_ack", a1 + a2 - b, 1);
      if (i == 7) check("draw_turn8", turn, 2'b01);
    end
    check("draw_board", brd(), 18'b10_01_10_01_10_01_01_10_01);
    check("draw_over", game_over, 1);
    check("draw_winner", winner, 0);
    check("draw_turn", turn, 0);
    b = a1 + k1;
    p1_cell = 4;
    p1_req = 1;
    repeat (3) @(posedge clk);
    #1;
    check("draw_frozen", a1 + k1 - b, 0);
    p1_req = 0;
    @(posedge clk); #1;
    restart();
    // new_game beats a simultaneous legal move
    p1_cell = 0;
    p1_req = 1;
    new_game = 1;
    @(posedge clk); #1;
    check("coll_ack", p1_ack, 0);
    check("coll_board", brd(), 0);
    check("coll_turn", turn, 2'b01);
    new_game = 0;
    p1_req = 0;
    @(posedge clk); #1;
    // asynchronous reset while in CHECK
    p1_cell = 3;
    p1_req = 1;
    @(posedge clk); #1;
    check("ar_ack", p1_ack, 1);
    check("ar_turn_check", turn, 0);
    p1_req = 0;
    #2 reset = 0;
    #1;
    check("ar_board", brd(), 0);
    check("ar_turn", turn, 2'b01);
    check("ar_ack_clr", p1_ack, 0);
    #2 reset = 1;
    @(posedge clk); #1;
    check("ar_after", {brd(), turn}, {18'd0, 2'b01});
`ifdef MOVE_TIMEOUT_EN
    restart();
    repeat (7) @(posedge clk);
    #1;
    check("to_early", timeout_pulse, 0);
    @(posedge clk); #1;
    check("to_pulse", timeout_pulse, 1);
    check("to_turn", turn, 2'b10);
    check("to_board", brd(), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
